// File: rtl/fwrisc_uart_rx.sv
// rtl/fwrisc_uart_rx.sv - 8N1 UART receiver with valid/ready byte output
// Oversamples rx at CLKS_PER_BIT clocks per bit; flags framing errors and dropped bytes.
module fwrisc_uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx,
   output logic [7:0] dat_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       busy_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          done_q, done_d;
   logic          ferr_p_q, ferr_p_d;
   logic [7:0]    dat_q, dat_d;
   logic          valid_q, valid_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          busy_q, busy_d;
   logic          rx_s;
   logic          xfer;

   assign rx_s = sync_q[1];
   assign xfer = valid_q & ready_i;

   always_comb begin
      state_d     = state_q;
      sync_d      = {sync_q[0], rx};
      cnt_d       = cnt_q + CW'(1);
      idx_d       = idx_q;
      shift_d     = shift_q;
      done_d      = 1'b0;
      ferr_p_d    = 1'b0;
      dat_d       = dat_q;
      valid_d     = valid_q;
      frame_err_d = ferr_p_q;
      overrun_d   = 1'b0;
      busy_d      = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               idx_d = 3'd0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (rx_s) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_p_d = 1'b1;
                  state_d  = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Delivery lags the stop sample by one edge; a held byte is never overwritten.
      if (xfer) valid_d = 1'b0;
      if (done_q) begin
         if (!valid_q || xfer) begin
            dat_d   = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         sync_q      <= 2'b11;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         done_q      <= 1'b0;
         ferr_p_q    <= 1'b0;
         dat_q       <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         done_q      <= done_d;
         ferr_p_q    <= ferr_p_d;
         dat_q       <= dat_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign dat_o       = dat_q;
   assign valid_o     = valid_q;
   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;
   assign busy_o      = busy_q;

endmodule

// File: doc/fwrisc_uart_rx.md
# fwrisc_uart_rx

Bench-side UART receiver that decodes the serial `tx` line driven by the FPGA top-level into bytes for the testbench. It oversamples the line with a fixed clock-per-bit count, detects start, data and stop bits, and presents each received byte on a valid/ready handshake. It also flags framing errors and dropped bytes. It instantiates alongside the DUT in the FPGA testbench HDL and shares its clock.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be even and ≥ 4.

Ports:
- `clock`  in  1  sole clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, idle high, 8N1, LSB first. Asynchronous to `clock`.
- `dat_o`  out  8  received byte.
- `valid_o`  out  1  `dat_o` holds an unconsumed byte.
- `ready_i`  in  1  consumer accepts the byte; a transfer occurs on any edge where `valid_o & ready_i`.
- `frame_err_o`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun_o`  out  1  one-cycle pulse when a completed byte is dropped.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer**
  - `rx` passes through a 2-flop synchronizer to give `rx_s`.
  - Both flops reset to 1 so reset release cannot fake a start bit.
- **FSM states:** IDLE, START, DATA, STOP, BREAK. One bit counter `cnt` (width `$clog2(CLKS_PER_BIT)`) and a bit index `idx` (0..7).
- **IDLE:** when `rx_s==0`, go to START with `cnt=0`.
- **START**
  - At `cnt==CLKS_PER_BIT/2-1`, sample `rx_s`.
  - If 1, treat as a glitch: return to IDLE, no output.
  - If 0, go to DATA with `cnt=0`, `idx=0`.
- **DATA**
  - At `cnt==CLKS_PER_BIT-1`, shift `rx_s` into bit 7 of the shift register (shift right), reset `cnt`, increment `idx`.
  - After the sample with `idx==7`, go to STOP.
- **STOP:** at `cnt==CLKS_PER_BIT-1`, sample `rx_s`.
  - If 1, deliver the byte and go to IDLE. IDLE is re-entered mid-stop-bit, so a start bit that follows directly is caught.
  - If 0, pulse `frame_err_o`, discard the byte and go to BREAK.
- **BREAK:** stay until `rx_s==1`, then go to IDLE.
- **Delivery**
  - If `valid_o==0`, or a transfer happens on the same edge, load `dat_o` and set `valid_o=1`.
  - Otherwise pulse `overrun_o`, drop the new byte, and keep the old `dat_o`/`valid_o` unchanged.
- **Handshake**
  - `dat_o` is stable while `valid_o` is high.
  - `valid_o` clears on the transfer edge unless a new byte loads on that same edge.
- **Reset**
  - Reset values: `dat_o=0x00`, `valid_o=0`, `frame_err_o=0`, `overrun_o=0`, `busy_o=0`; FSM=IDLE, counters 0, shift register 0.
  - Asserting reset mid-frame aborts the frame. No partial byte or error is ever reported for it.

## Timing
- Let t0 be the edge where IDLE first sees `rx_s==0`. This is 2 edges after `rx` falls, due to the synchronizer.
- Start-bit sample: t0+`CLKS_PER_BIT/2`.
- Data bit i sample (i=0..7): t0+`CLKS_PER_BIT/2`+(i+1)·`CLKS_PER_BIT`.
- Stop sample: t0+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`. This is t0+152 for the default.
- Output timing:
  - `valid_o`, `frame_err_o` and `overrun_o` change on the edge after the stop sample (t0+153 for the default).
  - Error pulses are exactly 1 cycle.
- `busy_o`:
  - Rises on the edge after t0.
  - Falls when the FSM returns to IDLE (after the stop sample, glitch rejection, or BREAK exit).
- Tolerance: line baud may deviate ±3% from `CLKS_PER_BIT` with correct decode.
- Throughput: back-to-back frames with one stop bit are received with no loss while `ready_i` is held high.

## Test plan
- **Single byte:** `CLKS_PER_BIT=16`, `ready_i=1`, send 0xA5 → `valid_o` high one cycle at t0+153 with `dat_o=0xA5`; `busy_o` low afterwards; no error pulses.
- **Back-to-back:** 0x00, 0xFF, 0x5A with no idle gap, `ready_i=1` → three transfers in order, no `overrun_o`, no `frame_err_o`.
- **Glitch:** `rx` low for 4 cycles, then high → no `valid_o`; `busy_o` returns to 0 by t0+9; next byte 0x3C decodes correctly.
- **Framing error:** send 0x55 with stop bit driven 0, hold `rx` low 40 more cycles, then release → one `frame_err_o` pulse, no `valid_o`, `busy_o` high until `rx_s` returns to 1; subsequent 0x81 decodes correctly.
- **Overrun:** `ready_i=0`, send 0x12 then 0x34 → `valid_o=1` with `dat_o=0x12` throughout, one `overrun_o` pulse at the second stop; raising `ready_i` transfers 0x12 and `valid_o` falls.
- **Reset mid-frame:** pulse `reset_n` low for 3 cycles during data bit 4 of 0xC3, then send 0x7E → all outputs 0 during reset, no byte and no error from the aborted frame, 0x7E received correctly.
